// File: rtl/fsm_game_mp_if.sv
// Shared message/state types and the button/display bus between the strobe
// conditioners, the multi-player game controller and the stopwatch path.
package datatype_package;
  typedef enum logic [2:0] {
    EMPTY_MSG,
    WELCOME_MSG,
    READY_MSG,
    STOPWATCH_MSG,
    WIN_MSG,
    LOSE_MSG
  } msg_t;

  typedef enum logic [2:0] {
    IDLE_S,
    WELCOME_S,
    READY_S,
    RUN_S,
    SHOOT_S,
    WIN_S,
    SCORE_S,
    LOSE_S
  } game_state_t;
endpackage

interface fsm_game_mp_if #(
  parameter int N_PLAYERS = 2,
  parameter int MAX_SHOTS = 6
);
  import datatype_package::*;

  localparam int PW = (N_PLAYERS > 1) ? $clog2(N_PLAYERS) : 1;
  localparam int SW = $clog2(MAX_SHOTS + 1);

  logic [N_PLAYERS-1:0] btn_stb_i;
  logic                 win_i;
  logic                 reset_o;
  logic                 pause_o;
  msg_t                 msg_o;
  logic [PW-1:0]        player_o;
  logic [SW-1:0]        shots_left_o;
  logic                 winner_vld_o;

  modport master (
    output btn_stb_i, win_i,
    input  reset_o, pause_o, msg_o, player_o, shots_left_o, winner_vld_o
  );

  modport slave (
    input  btn_stb_i, win_i,
    output reset_o, pause_o, msg_o, player_o, shots_left_o, winner_vld_o
  );
endinterface

// File: rtl/fsm_game_mp.sv
// Multi-player stopwatch game controller: players shoot in turn from a shared
// shot budget; the game ends in a win (first on-target stop) or a lose.
module fsm_game_mp
  import datatype_package::*;
#(
  parameter int N_PLAYERS                = 2,
  parameter int MAX_SHOTS                = 6,
  parameter int PAUSE_DURATINON_HW_TICKS = 5
) (
  input  logic          clk_i,
  input  logic          res_i,
  fsm_game_mp_if.slave  bus
);
  localparam int PW = (N_PLAYERS > 1) ? $clog2(N_PLAYERS) : 1;
  localparam int SW = $clog2(MAX_SHOTS + 1);
  localparam int TW = $clog2(PAUSE_DURATINON_HW_TICKS + 1);

  game_state_t   r_state;
  game_state_t   w_state_next;
  logic [TW-1:0] r_timer;
  logic [PW-1:0] r_player;
  logic [SW-1:0] r_shots;
  logic          r_winner_vld;

  logic          w_any_btn;
  logic          w_shot;
  logic          w_timer_last;
  logic          w_timed;
  logic [PW-1:0] w_player_inc;

  assign w_any_btn    = |bus.btn_stb_i;
  assign w_shot       = bus.btn_stb_i[r_player];
  assign w_timer_last = (r_timer == TW'(PAUSE_DURATINON_HW_TICKS - 1));
  assign w_timed      = (r_state == READY_S) || (r_state == SHOOT_S) ||
                        (r_state == WIN_S)   || (r_state == SCORE_S);
  assign w_player_inc = (r_player == PW'(N_PLAYERS - 1)) ? '0 : r_player + PW'(1);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE_S:    w_state_next = WELCOME_S;
      WELCOME_S: if (w_any_btn) w_state_next = READY_S;
      READY_S:   if (w_timer_last) w_state_next = RUN_S;
      RUN_S:     if (w_shot) w_state_next = SHOOT_S;
      SHOOT_S: begin
        if (w_timer_last) begin
          if (bus.win_i)          w_state_next = WIN_S;
          else if (r_shots == '0) w_state_next = LOSE_S;
          else                    w_state_next = RUN_S;
        end
      end
      // A button press wins over the WIN/SCORE toggle on the same edge.
      WIN_S: begin
        if (w_any_btn)         w_state_next = IDLE_S;
        else if (w_timer_last) w_state_next = SCORE_S;
      end
      SCORE_S: begin
        if (w_any_btn)         w_state_next = IDLE_S;
        else if (w_timer_last) w_state_next = WIN_S;
      end
      LOSE_S:    if (w_any_btn) w_state_next = IDLE_S;
      default:   w_state_next = IDLE_S;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!res_i) begin
      r_state      <= IDLE_S;
      r_timer      <= '0;
      r_player     <= '0;
      r_shots      <= SW'(MAX_SHOTS);
      r_winner_vld <= 1'b0;
    end else begin
      r_state <= w_state_next;

      if (w_state_next != r_state) r_timer <= '0;
      else if (w_timed)            r_timer <= r_timer + TW'(1);

      case (r_state)
        IDLE_S: begin
          r_shots      <= SW'(MAX_SHOTS);
          r_player     <= '0;
          r_winner_vld <= 1'b0;
        end
        RUN_S: if (w_shot) r_shots <= r_shots - SW'(1);
        SHOOT_S: begin
          if (w_timer_last) begin
            if (bus.win_i)          r_winner_vld <= 1'b1;
            else if (r_shots != '0) r_player     <= w_player_inc;
          end
        end
        default: ;
      endcase

      // Winner flag only describes the finished game, so drop it on the way out.
      if (w_state_next == IDLE_S) r_winner_vld <= 1'b0;
    end
  end

  always_comb begin
    bus.reset_o = 1'b0;
    bus.pause_o = 1'b1;
    bus.msg_o   = EMPTY_MSG;
    case (r_state)
      IDLE_S:    bus.reset_o = 1'b1;
      WELCOME_S: bus.msg_o   = WELCOME_MSG;
      READY_S:   bus.msg_o   = READY_MSG;
      RUN_S: begin
        bus.pause_o = 1'b0;
        bus.msg_o   = STOPWATCH_MSG;
      end
      SHOOT_S:   bus.msg_o   = STOPWATCH_MSG;
      WIN_S:     bus.msg_o   = WIN_MSG;
      SCORE_S:   bus.msg_o   = STOPWATCH_MSG;
      LOSE_S:    bus.msg_o   = LOSE_MSG;
      default:   bus.msg_o   = EMPTY_MSG;
    endcase
  end

  assign bus.player_o     = r_player;
  assign bus.shots_left_o = r_shots;
  assign bus.winner_vld_o = r_winner_vld;
endmodule

// File: tb/tb_fsm_game_mp.sv
// Bench for fsm_game_mp: directed game scenarios with literal expectations,
// then random buttons/win/reset checked every cycle against a phase model.
module tb_fsm_game_mp;
  import datatype_package::*;

  localparam int N  = 2;
  localparam int MS = 6;
  localparam int P  = 5;

  localparam int PH_IDLE    = 0;
  localparam int PH_WELCOME = 1;
  localparam int PH_READY   = 2;
  localparam int PH_RUN     = 3;
  localparam int PH_SHOOT   = 4;
  localparam int PH_WIN     = 5;
  localparam int PH_SCORE   = 6;
  localparam int PH_LOSE    = 7;

  logic clk;
  logic res;
  int   n_checks;
  int   n_errors;

  fsm_game_mp_if #(.N_PLAYERS(N), .MAX_SHOTS(MS)) bus ();

  fsm_game_mp #(
    .N_PLAYERS(N),
    .MAX_SHOTS(MS),
    .PAUSE_DURATINON_HW_TICKS(P)
  ) dut (
    .clk_i(clk),
    .res_i(res),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: phase plus "cycles left" countdown, kept in plain ints.
  int m_phase;
  int m_left;
  int m_player;
  int m_shots;
  int m_winner;

  always @(posedge clk) begin
    if (!res) begin
      m_phase = PH_IDLE; m_player = 0; m_shots = MS; m_winner = 0; m_left = 0;
    end else begin
      case (m_phase)
        PH_IDLE: begin
          m_phase = PH_WELCOME; m_shots = MS; m_player = 0; m_winner = 0;
        end
        PH_WELCOME: if (bus.btn_stb_i != 0) begin m_phase = PH_READY; m_left = P; end
        PH_READY: begin
          m_left--;
          if (m_left == 0) m_phase = PH_RUN;
        end
        PH_RUN: if (bus.btn_stb_i[m_player]) begin
          m_phase = PH_SHOOT; m_left = P; m_shots--;
        end
        PH_SHOOT: begin
          m_left--;
          if (m_left == 0) begin
            if (bus.win_i) begin m_phase = PH_WIN; m_winner = 1; m_left = P; end
            else if (m_shots == 0) m_phase = PH_LOSE;
            else begin m_phase = PH_RUN; m_player = (m_player + 1) % N; end
          end
        end
        PH_WIN, PH_SCORE: begin
          if (bus.btn_stb_i != 0) begin m_phase = PH_IDLE; m_winner = 0; end
          else begin
            m_left--;
            if (m_left == 0) begin
              m_phase = (m_phase == PH_WIN) ? PH_SCORE : PH_WIN;
              m_left = P;
            end
          end
        end
        default: if (bus.btn_stb_i != 0) m_phase = PH_IDLE;
      endcase
    end
  end

  function automatic int exp_msg(int ph);
    case (ph)
      PH_IDLE:    return int'(EMPTY_MSG);
      PH_WELCOME: return int'(WELCOME_MSG);
      PH_READY:   return int'(READY_MSG);
      PH_WIN:     return int'(WIN_MSG);
      PH_LOSE:    return int'(LOSE_MSG);
      default:    return int'(STOPWATCH_MSG);
    endcase
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    #1;
    check("model.reset_o", int'(bus.reset_o), (m_phase == PH_IDLE) ? 1 : 0);
    check("model.pause_o", int'(bus.pause_o), (m_phase == PH_RUN) ? 0 : 1);
    check("model.msg_o",   int'(bus.msg_o),   exp_msg(m_phase));
    check("model.player_o", int'(bus.player_o), m_player);
    check("model.shots_left_o", int'(bus.shots_left_o), m_shots);
    check("model.winner_vld_o", int'(bus.winner_vld_o), m_winner);
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input int bits);
    bus.btn_stb_i = N'(bits);
    step(1);
    bus.btn_stb_i = '0;
  endtask

  initial begin
    int p;
    n_checks = 0;
    n_errors = 0;
    res = 1'b0;
    bus.btn_stb_i = '0;
    bus.win_i = 1'b0;
    step(2);
    res = 1'b1;
    check("rst.msg",   int'(bus.msg_o), int'(EMPTY_MSG));
    check("rst.reset", int'(bus.reset_o), 1);
    check("rst.pause", int'(bus.pause_o), 1);
    check("rst.shots", int'(bus.shots_left_o), 6);
    step(1);
    check("welcome.msg",   int'(bus.msg_o), int'(WELCOME_MSG));
    check("welcome.reset", int'(bus.reset_o), 0);

    press(2'b10);
    check("ready.msg", int'(bus.msg_o), int'(READY_MSG));
    step(4);
    check("ready.last", int'(bus.msg_o), int'(READY_MSG));
    step(1);
    check("run.pause",  int'(bus.pause_o), 0);
    check("run.player", int'(bus.player_o), 0);

    press(2'b10);
    check("run.wrongbtn", int'(bus.pause_o), 0);
    press(2'b01);
    check("shoot.shots", int'(bus.shots_left_o), 5);
    check("shoot.pause", int'(bus.pause_o), 1);
    step(4);
    check("shoot.last", int'(bus.pause_o), 1);
    step(1);
    check("turn.player", int'(bus.player_o), 1);
    check("turn.pause",  int'(bus.pause_o), 0);

    p = 1;
    for (int s = 0; s < 5; s++) begin
      press(1 << p);
      step(5);
      p = (p + 1) % N;
    end
    check("lose.msg",   int'(bus.msg_o), int'(LOSE_MSG));
    check("lose.shots", int'(bus.shots_left_o), 0);
    press(2'b01);
    check("lose.exit", int'(bus.reset_o), 1);
    step(1);

    press(2'b01);
    step(5);
    press(2'b01);
    step(5);
    check("win.turn", int'(bus.player_o), 1);
    bus.win_i = 1'b1;
    press(2'b10);
    step(5);
    bus.win_i = 1'b0;
    check("win.msg",    int'(bus.msg_o), int'(WIN_MSG));
    check("win.vld",    int'(bus.winner_vld_o), 1);
    check("win.player", int'(bus.player_o), 1);
    check("win.shots",  int'(bus.shots_left_o), 4);
    step(5);
    check("score.msg", int'(bus.msg_o), int'(STOPWATCH_MSG));
    check("score.vld", int'(bus.winner_vld_o), 1);
    step(5);
    check("win2.msg", int'(bus.msg_o), int'(WIN_MSG));
    step(4);
    press(2'b01);
    check("win.exit", int'(bus.reset_o), 1);
    step(1);

    press(2'b01);
    step(5);
    press(2'b01);
    step(2);
    res = 1'b0;
    step(1);
    res = 1'b1;
    check("midrst.reset",  int'(bus.reset_o), 1);
    check("midrst.shots",  int'(bus.shots_left_o), 6);
    check("midrst.player", int'(bus.player_o), 0);
    step(1);
    check("midrst.welcome", int'(bus.msg_o), int'(WELCOME_MSG));
    press(2'b10);
    bus.btn_stb_i = 2'b11;
    step(3);
    bus.btn_stb_i = '0;
    step(1);
    check("readybtn.msg", int'(bus.msg_o), int'(READY_MSG));
    step(1);
    check("readybtn.run", int'(bus.pause_o), 0);

    for (int c = 0; c < 4000; c++) begin
      for (int b = 0; b < N; b++) bus.btn_stb_i[b] = ($urandom_range(0, 5) == 0);
      bus.win_i = ($urandom_range(0, 4) == 0);
      res = ($urandom_range(0, 399) != 0);
      step(1);
    end
    res = 1'b1;
    bus.btn_stb_i = '0;
    bus.win_i = 1'b0;
    step(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
